// File: rtl/bnn_conv1_sched_if.sv
// Request/result/write bundle between the layer-1 sequencer and its neighbours.
// Latency: none, wires only.
// Backpressure: win_ready stalls requests; results and buffer writes are not stallable.
interface bnn_conv1_sched_if #(
  parameter int RW = 5,
  parameter int FW = 3
);
  logic          win_valid;
  logic          win_ready;
  logic [RW-1:0] win_row;
  logic [RW-1:0] win_col;
  logic [FW-1:0] win_filt;
  logic          res_valid;
  logic          res_bit;
  logic          out_we;
  logic [RW-1:0] out_row;
  logic [RW-1:0] out_col;
  logic [FW-1:0] out_filt;
  logic          out_bit;

  modport master (
    output win_valid, win_row, win_col, win_filt,
    input  win_ready,
    input  res_valid, res_bit,
    output out_we, out_row, out_col, out_filt, out_bit
  );

  modport slave (
    input  win_valid, win_row, win_col, win_filt,
    output win_ready,
    output res_valid, res_bit,
    input  out_we, out_row, out_col, out_filt, out_bit
  );
endinterface

// File: rtl/bnn_conv1_sched.sv
// Layer-1 window sequencer: every KxK window for every kernel, in-order tag tracking, feature-buffer writes.
// Latency: buffer write one cycle after each result strobe; requests can issue every cycle.
// Backpressure: request fields hold while win_ready is low; issue stops at MAX_OUT outstanding; results never stall.
module bnn_conv1_sched #(
  parameter int IMG     = 28,
  parameter int K       = 3,
  parameter int NFILT   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  bnn_conv1_sched_if.master bus,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int OD = IMG - K + 1;
  localparam int RW = $clog2(IMG);
  localparam int FW = $clog2(NFILT);
  localparam int TW = 2 * RW + FW;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [RW-1:0] RC_LAST = RW'(OD - 1);
  localparam logic [FW-1:0] F_LAST  = FW'(NFILT - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(MAX_OUT - 1);
  localparam logic [OW-1:0] O_MAX   = OW'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;

  logic [RW-1:0] row, col;
  logic [FW-1:0] filt;
  logic          all_issued;
  logic [OW-1:0] outst;
  logic [TW-1:0] tag_mem [MAX_OUT];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, launch, last_req;
  logic          out_we_q, out_bit_q, err_q;
  logic [RW-1:0] out_row_q, out_col_q;
  logic [FW-1:0] out_filt_q;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + 1'b1;
  endfunction

  assign launch   = (state == IDLE) && start;
  assign bus.win_valid = (state == RUN) && !all_issued && (outst < O_MAX);
  assign push     = bus.win_valid && bus.win_ready;
  // Results with nothing outstanding, or outside RUN, are dropped and flagged.
  assign pop      = bus.res_valid && (state == RUN) && (outst != '0);
  assign last_req = (row == RC_LAST) && (col == RC_LAST) && (filt == F_LAST);

  assign bus.win_row  = row;
  assign bus.win_col  = col;
  assign bus.win_filt = filt;
  assign bus.out_we   = out_we_q;
  assign bus.out_row  = out_row_q;
  assign bus.out_col  = out_col_q;
  assign bus.out_filt = out_filt_q;
  assign bus.out_bit  = out_bit_q;
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign err  = err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state: RUN ends once the last tag has been written out.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (all_issued && (outst == '0) && out_we_q) state_n = DONE;
      DONE:    if (!start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Issue counters: filt innermost, then col, then row; they park on the last window.
  always_ff @(posedge clk) begin
    if (reset || launch) begin
      row        <= '0;
      col        <= '0;
      filt       <= '0;
      all_issued <= 1'b0;
    end else if (push) begin
      if (last_req) begin
        all_issued <= 1'b1;
      end else if (filt == F_LAST) begin
        filt <= '0;
        if (col == RC_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        filt <= filt + 1'b1;
      end
    end
  end

  // Outstanding count and tag FIFO pointers; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset || launch) begin
      outst  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !pop)      outst <= outst + 1'b1;
      else if (pop && !push) outst <= outst - 1'b1;
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
    end
  end

  // Tag storage; push never targets the head slot being popped because a slot is always free.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= {row, col, filt};
  end

  // Feature-buffer write port: one-cycle registered copy of the retired tag and its result bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_we_q   <= 1'b0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      out_filt_q <= '0;
      out_bit_q  <= 1'b0;
    end else begin
      out_we_q <= pop;
      if (pop) begin
        {out_row_q, out_col_q, out_filt_q} <= tag_mem[rd_ptr];
        out_bit_q <= bus.res_bit;
      end
    end
  end

  // Sticky protocol error; a spurious strobe wins over the clear on a new run.
  always_ff @(posedge clk) begin
    if (reset)                          err_q <= 1'b0;
    else if (bus.res_valid && !pop)     err_q <= 1'b1;
    else if (launch)                    err_q <= 1'b0;
  end
endmodule
